// File: rtl/pc_control_pkg.sv
// Shared types and constants for the fetch-stage next-PC logic.
// Condition codes, flag bit positions and the sequential PC increment.
package pc_control_pkg;

    typedef enum logic [2:0] {
        CC_NE     = 3'b000,
        CC_EQ     = 3'b001,
        CC_GT     = 3'b010,
        CC_LT     = 3'b011,
        CC_GE     = 3'b100,
        CC_LE     = 3'b101,
        CC_OV     = 3'b110,
        CC_UNCOND = 3'b111
    } cond_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    localparam int PC_INC = 2;

endpackage

// File: rtl/pc_control_if.sv
// Operand/result bundle between the decode stage and pc_control.
// Optional counter outputs exist only when PC_CONTROL_STATS_EN is defined.
interface pc_control_if #(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9
);
    logic [2:0]       C;
    logic [IMM_W-1:0] I;
    logic [2:0]       F;
    logic [PC_W-1:0]  Rs;
    logic             Branch;
    logic             BR;
    logic [PC_W-1:0]  PC_in;
    logic [PC_W-1:0]  PC_out;
    logic             taken;
    logic             taken_q;
    logic [PC_W-1:0]  pc_out_q;
`ifdef PC_CONTROL_STATS_EN
    logic [15:0]      br_count;
    logic [15:0]      br_taken_count;

    modport master (output C, I, F, Rs, Branch, BR, PC_in,
                    input  PC_out, taken, taken_q, pc_out_q, br_count, br_taken_count);
    modport slave  (input  C, I, F, Rs, Branch, BR, PC_in,
                    output PC_out, taken, taken_q, pc_out_q, br_count, br_taken_count);
`else
    modport master (output C, I, F, Rs, Branch, BR, PC_in,
                    input  PC_out, taken, taken_q, pc_out_q);
    modport slave  (input  C, I, F, Rs, Branch, BR, PC_in,
                    output PC_out, taken, taken_q, pc_out_q);
`endif
endinterface

// File: rtl/pc_control_branch_cond_eval.sv
// Decodes the 3-bit condition code against the Z/V/N flags.
// Latency: purely combinational. Backpressure: none.
module branch_cond_eval
    import pc_control_pkg::*;
(
    input  logic [2:0] C,
    input  logic [2:0] F,
    output logic       cond
);
    logic z, v, n;

    assign z = F[FLAG_Z];
    assign v = F[FLAG_V];
    assign n = F[FLAG_N];

    always_comb begin
        cond = 1'b0;
        case (cond_e'(C))
            CC_NE:     cond = ~z;
            CC_EQ:     cond = z;
            CC_GT:     cond = ~z & ~n;
            CC_LT:     cond = n;
            CC_GE:     cond = z | ~n;
            CC_LE:     cond = z | n;
            CC_OV:     cond = v;
            CC_UNCOND: cond = 1'b1;
            default:   cond = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_control.sv
// Next-PC computation (sequential / PC-relative immediate / PC+Rs) with registered status; PC_CONTROL_STATS_EN adds branch counters.
// Latency: PC_out/taken combinational, taken_q/pc_out_q one clk edge later.
// Backpressure: none; a new decision is accepted every cycle.
module pc_control
    import pc_control_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9
) (
    input  logic         clk,
    input  logic         rst,
    pc_control_if.slave  bus
);
    logic            cond;
    logic            taken;
    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] imm_ext;
    logic [PC_W-1:0] imm_off;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] pc_next;
    logic            taken_q;
    logic [PC_W-1:0] pc_out_q;

    branch_cond_eval u_cond (
        .C    (bus.C),
        .F    (bus.F),
        .cond (cond)
    );

    assign taken   = bus.Branch & cond;
    assign seq     = bus.PC_in + PC_W'(PC_INC);
    assign imm_ext = {{(PC_W-IMM_W){bus.I[IMM_W-1]}}, bus.I};
    assign imm_off = {imm_ext[PC_W-2:0], 1'b0};

    // Muxes (not AND-masking) keep an unknown unused operand from leaking into PC_out.
    always_comb begin
        offset  = bus.BR ? bus.Rs : imm_off;
        pc_next = seq;
        if (taken) begin
            pc_next = seq + offset;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q  <= 1'b0;
            pc_out_q <= '0;
        end else begin
            taken_q  <= taken;
            pc_out_q <= pc_next;
        end
    end

    assign bus.PC_out   = pc_next;
    assign bus.taken    = taken;
    assign bus.taken_q  = taken_q;
    assign bus.pc_out_q = pc_out_q;

`ifdef PC_CONTROL_STATS_EN
    logic [15:0] br_count;
    logic [15:0] br_taken_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count       <= '0;
            br_taken_count <= '0;
        end else begin
            if (bus.Branch && br_count != 16'hFFFF) begin
                br_count <= br_count + 16'd1;
            end
            if (taken && br_taken_count != 16'hFFFF) begin
                br_taken_count <= br_taken_count + 16'd1;
            end
        end
    end

    assign bus.br_count       = br_count;
    assign bus.br_taken_count = br_taken_count;
`endif
endmodule

// File: tb/tb_pc_control.sv
// Directed table-driven bench for pc_control plus hand sequences for the registered path.
// Covers default/immediate/register targets, condition sweep, wrap-around, reset and optional counters.
module tb_pc_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pc_control_if #(.PC_W(16), .IMM_W(9)) bus ();

    pc_control #(.PC_W(16), .IMM_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        branch;
        logic        br;
        logic [2:0]  c;
        logic [2:0]  f;
        logic [8:0]  i;
        logic [15:0] rs;
        logic [15:0] pc_in;
        logic [15:0] exp_pc;
        logic        exp_taken;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic branch, input logic br, input logic [2:0] c,
                         input logic [2:0] f, input logic [8:0] i, input logic [15:0] rs,
                         input logic [15:0] pc_in);
        bus.Branch = branch;
        bus.BR     = br;
        bus.C      = c;
        bus.F      = f;
        bus.I      = i;
        bus.Rs     = rs;
        bus.PC_in  = pc_in;
    endtask

    // Independent reading of the condition table: F = {Z, V, N}.
    function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return z || n;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        logic exp_t;

        //           br  BR  C     F       I       Rs        PC_in     exp_pc    taken
        vecs[0]  = '{1'b0, 1'b0, 3'd3, 3'b101, 9'h1AB, 16'h1234, 16'h0000, 16'h0002, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd1, 3'b100, 9'h004, 16'h0000, 16'h0010, 16'h001A, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 3'd1, 3'b100, 9'h1FE, 16'h0000, 16'h0010, 16'h000E, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 3'd7, 3'b000, 9'h000, 16'h0200, 16'h1000, 16'h1202, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 3'd7, 3'b000, 9'h000, 16'hFFFE, 16'h1000, 16'h1000, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 3'd7, 3'b000, 9'h010, 16'h0000, 16'hFFFE, 16'h0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'd7, 3'b000, 9'h000, 16'h0020, 16'hFFF0, 16'h0012, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 3'd1, 3'b000, 9'h004, 16'h0000, 16'h0010, 16'h0012, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 3'd0, 3'b100, 9'h000, 16'h0500, 16'h0020, 16'h0022, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'd7, 3'b000, 9'h100, 16'h0000, 16'h1000, 16'h0E02, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 3'd7, 3'b000, 9'h0FF, 16'h0000, 16'h1000, 16'h1200, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 3'd7, 3'b000, 9'h1FF, 16'h0004, 16'h0000, 16'h0006, 1'b1};

        // Reset state, with a taken branch presented so the clear is meaningful.
        drive(1'b1, 1'b0, 3'd7, 3'b000, 9'h002, 16'h0000, 16'h0040);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_taken_q", 32'(bus.taken_q), 32'h0);
        chk("reset_pc_out_q", 32'(bus.pc_out_q), 32'h0);
        chk("comb_pc_during_rst", 32'(bus.PC_out), 32'h0046);
        chk("comb_taken_during_rst", 32'(bus.taken), 32'h1);
`ifdef PC_CONTROL_STATS_EN
        chk("reset_br_count", 32'(bus.br_count), 32'h0);
        chk("reset_br_taken_count", 32'(bus.br_taken_count), 32'h0);
`endif

        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(vecs[k].branch, vecs[k].br, vecs[k].c, vecs[k].f, vecs[k].i,
                  vecs[k].rs, vecs[k].pc_in);
            #1;
            chk($sformatf("vec%0d_pc_out", k), 32'(bus.PC_out), 32'(vecs[k].exp_pc));
            chk($sformatf("vec%0d_taken", k), 32'(bus.taken), 32'(vecs[k].exp_taken));
        end

        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                @(negedge clk);
                drive(1'b1, 1'b0, 3'(c), 3'(f), 9'h010, 16'h0000, 16'h0100);
                #1;
                exp_t = ref_cond(3'(c), 3'(f));
                chk($sformatf("sweep_c%0d_f%0d_pc", c, f), 32'(bus.PC_out),
                    exp_t ? 32'h0122 : 32'h0102);
                chk($sformatf("sweep_c%0d_f%0d_taken", c, f), 32'(bus.taken), 32'(exp_t));
            end
        end

        // Unknown Rs must not reach PC_out when it is not selected.
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd7, 3'b000, 9'h004, 16'hxxxx, 16'h0010);
        #1;
        chk("x_rs_imm_branch", 32'(bus.PC_out), 32'h001A);
        drive(1'b0, 1'b1, 3'd7, 3'b000, 9'h004, 16'hxxxx, 16'h0010);
        #1;
        chk("x_rs_no_branch", 32'(bus.PC_out), 32'h0012);

        // Registered path: clear, then a taken branch, then a sequential step.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 3'b000, 9'h000, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'd7, 3'b000, 9'h002, 16'h0000, 16'h0040);
        @(posedge clk);
        #1;
        chk("reg_taken_q", 32'(bus.taken_q), 32'h1);
        chk("reg_pc_out_q", 32'(bus.pc_out_q), 32'h0046);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd1, 3'b000, 9'h002, 16'h0000, 16'h0040);
        @(posedge clk);
        #1;
        chk("reg_nt_taken_q", 32'(bus.taken_q), 32'h0);
        chk("reg_nt_pc_out_q", 32'(bus.pc_out_q), 32'h0042);
`ifdef PC_CONTROL_STATS_EN
        chk("stats_br_count_2", 32'(bus.br_count), 32'h2);
        chk("stats_br_taken_count_1", 32'(bus.br_taken_count), 32'h1);
`endif

        // Mid-operation reset clears only the registers at the next edge.
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd7, 3'b000, 9'h000, 16'h0010, 16'h0100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_taken_q", 32'(bus.taken_q), 32'h0);
        chk("midrst_pc_out_q", 32'(bus.pc_out_q), 32'h0);
        chk("midrst_comb_pc", 32'(bus.PC_out), 32'h0112);

`ifdef PC_CONTROL_STATS_EN
        // Three Branch cycles, two of them taken.
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'd7, 3'b000, 9'h000, 16'h0000, 16'h0000);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd1, 3'b100, 9'h000, 16'h0004, 16'h0000);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd1, 3'b000, 9'h000, 16'h0000, 16'h0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd7, 3'b000, 9'h000, 16'h0000, 16'h0000);
        #1;
        chk("stats_br_count", 32'(bus.br_count), 32'h3);
        chk("stats_br_taken_count", 32'(bus.br_taken_count), 32'h2);
        @(posedge clk);
        #1;
        chk("stats_hold_br_count", 32'(bus.br_count), 32'h3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
